n64a_csc_pipe: RTL and testbench

- Parametrised successor to the fixed RGB->YPbPr converter in the video output path.
- Converts pixels between DAC-ready formats in a fixed-latency pipeline: RGB bypass, YPbPr Rec.601 or YPbPr Rec.709.
- Sits between the post-processing chain and the ADV712x DAC interface.
- Mode changes take effect only at a frame boundary (nVSYNC falling edge), so a frame never has mixed colour spaces.

---
 rtl/n64a_csc_pipe.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_n64a_csc_pipe.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/n64a_csc_pipe.sv
// n64a_csc_pipe: fixed-latency (4 VCLK) colour-space converter for the DAC path.
// Output modes: RGB bypass, YPbPr Rec.601 and YPbPr Rec.709.
// The output format is {S, V1, V2, V3}, with {S, Pr, Y, Pb} in the YPbPr modes.
// Each pixel carries its own mode tag through the pipe. A requested mode is applied
// only on the pixel that carries a falling nVSYNC edge.
// Optional build macro CSC_LIMITED_RANGE_EN selects limited-range output in every mode.
// It does this by folding the range scaling into the coefficients and offsets.
// Without the macro the output is full range, and bypass is a plain delay line.
module n64a_csc_pipe #(
    parameter int COLOR_W = 8,
    parameter int COEFF_W = 18,
    parameter int SYNC_W  = 4
) (
    input  logic                        VCLK,
    input  logic                        VRST,
    input  logic [1:0]                  mode_i,
    input  logic [SYNC_W+3*COLOR_W-1:0] vdata_i,
    output logic [SYNC_W+3*COLOR_W-1:0] vdata_o,
    output logic [1:0]                  mode_o,
    output logic                        pend_o
);

    localparam int  PIX_W = SYNC_W + 3*COLOR_W;
    localparam int  CW    = COEFF_W + 2;            // |c| < 1, so sign plus one integer bit
    localparam int  ACC_W = COLOR_W + COEFF_W + 3;
    localparam real SCALE = 2.0 ** COEFF_W;

    localparam logic [1:0] M_BYP = 2'b00;
    localparam logic [1:0] M_601 = 2'b01;
    localparam logic [1:0] M_709 = 2'b10;

`ifdef CSC_LIMITED_RANGE_EN
    localparam real SY      = 219.0 / 255.0;        // luma / RGB excursion
    localparam real SC      = 224.0 / 255.0;        // chroma excursion
    localparam int  CARRY_W = SYNC_W;               // only sync rides alongside the math
`else
    localparam real SY      = 1.0;
    localparam real SC      = 1.0;
    localparam int  CARRY_W = PIX_W;                // whole pixel rides along for bypass
`endif

    // Round-to-nearest fixed-point coefficient, computed at elaboration.
    function automatic logic signed [CW-1:0] q(input real c);
        real s;
        s = c * SCALE;
        s = (s >= 0.0) ? s + 0.5 : s - 0.5;
        return CW'($rtoi(s));
    endfunction

    // The coefficients are indexed by 3*out_channel + in_channel.
    // The output channels are V1, V2, V3 and the input channels are R, G, B.
    localparam logic signed [CW-1:0] KZ = '0;
    localparam logic signed [CW-1:0] K601 [9] = '{
        q( 0.5*SC),      q(-0.418688*SC), q(-0.081312*SC),   // Pr
        q( 0.299*SY),    q( 0.587*SY),    q( 0.114*SY),      // Y
        q(-0.168736*SC), q(-0.331264*SC), q( 0.5*SC)         // Pb
    };
    localparam logic signed [CW-1:0] K709 [9] = '{
        q( 0.5*SC),      q(-0.454153*SC), q(-0.045847*SC),   // Pr
        q( 0.2126*SY),   q( 0.7152*SY),   q( 0.0722*SY),     // Y
        q(-0.114572*SC), q(-0.385428*SC), q( 0.5*SC)         // Pb
    };
`ifdef CSC_LIMITED_RANGE_EN
    localparam logic signed [CW-1:0] KBYP [9] = '{
        q(SY), KZ,    KZ,
        KZ,    q(SY), KZ,
        KZ,    KZ,    q(SY)
    };
    localparam logic signed [ACC_W-1:0] OFF_Y = ACC_W'(64'd16 << (COLOR_W - 8 + COEFF_W));
`else
    // Bypass never uses the multiplier results in full range.
    localparam logic signed [CW-1:0] KBYP [9] = '{KZ, KZ, KZ, KZ, KZ, KZ, KZ, KZ, KZ};
    localparam logic signed [ACC_W-1:0] OFF_Y = '0;
`endif
    localparam logic signed [ACC_W-1:0] OFF_C = ACC_W'(64'd1 << (COLOR_W - 1 + COEFF_W));
    localparam logic signed [ACC_W-1:0] HALF  = ACC_W'(64'd1 << (COEFF_W - 1));
    localparam logic signed [ACC_W-1:0] MAXV  = ACC_W'((64'd1 << COLOR_W) - 64'd1);
    localparam logic signed [ACC_W-1:0] OFF_YPB [3] = '{OFF_C, OFF_Y, OFF_C};
    localparam logic signed [ACC_W-1:0] OFF_BYP [3] = '{OFF_Y, OFF_Y, OFF_Y};

    // ------------------------------------------------------------------
    // Mode FSM
    // ------------------------------------------------------------------
    typedef enum logic {ST_RUN, ST_PEND} state_t;

    state_t     state_q, state_d;
    logic [1:0] mode_q, mode_d;
    logic [1:0] mode_req;
    logic       vs_prev_q, vs_prev_d;
    logic       vs_fall;

    assign mode_req = (mode_i == 2'b11) ? M_BYP : mode_i;

    // Next-state and applied mode. While in PEND, the pending request always equals
    // the current mode_i. On a frame boundary the live value is applied directly, so
    // no separate request register is kept.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        vs_prev_d = vdata_i[PIX_W-1];
        vs_fall   = vs_prev_q & ~vdata_i[PIX_W-1];
        case (state_q)
            ST_RUN: begin
                if (mode_req != mode_q) begin
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (vs_fall) begin
                    mode_d  = mode_req;
                    state_d = ST_RUN;
                end else if (mode_req == mode_q) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // State register. During reset the applied mode is taken straight from mode_i.
    always_ff @(posedge VCLK) begin
        if (VRST) begin
            state_q   <= ST_RUN;
            mode_q    <= mode_req;
            vs_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            vs_prev_q <= vs_prev_d;
        end
    end

    assign mode_o = mode_q;
    assign pend_o = (state_q == ST_PEND);

    // ------------------------------------------------------------------
    // Pipeline control: data, tag and valid travel together
    // ------------------------------------------------------------------
    logic [PIX_W-1:0]   s1_data_q, s1_data_d;
    logic [1:0]         s1_tag_q, s1_tag_d;
    logic               s1_vld_q, s1_vld_d;
    logic [CARRY_W-1:0] s2_carry_q, s2_carry_d;
    logic [1:0]         s2_tag_q, s2_tag_d;
    logic               s2_vld_q, s2_vld_d;
    logic [CARRY_W-1:0] s3_carry_q, s3_carry_d;
    logic               s3_vld_q, s3_vld_d;
    logic [PIX_W-1:0]   vdata_q, vdata_d;
    logic [PIX_W-1:0]   conv;
`ifndef CSC_LIMITED_RANGE_EN
    logic [1:0]         s3_tag_q, s3_tag_d;
`endif

    // Stage advance for everything except the products and sums.
    always_comb begin
        s1_data_d  = vdata_i;
        s1_tag_d   = mode_d;               // the mode applied to the pixel entering now
        s1_vld_d   = 1'b1;
        s2_carry_d = s1_data_q[PIX_W-1 -: CARRY_W];
        s2_tag_d   = s1_tag_q;
        s2_vld_d   = s1_vld_q;
        s3_carry_d = s2_carry_q;
        s3_vld_d   = s2_vld_q;
`ifndef CSC_LIMITED_RANGE_EN
        s3_tag_d   = s2_tag_q;
`endif
    end

    // Pipeline control registers. Reset discards every pixel in flight.
    always_ff @(posedge VCLK) begin
        if (VRST) begin
            s1_data_q  <= '0;
            s1_tag_q   <= '0;
            s1_vld_q   <= 1'b0;
            s2_carry_q <= '0;
            s2_tag_q   <= '0;
            s2_vld_q   <= 1'b0;
            s3_carry_q <= '0;
            s3_vld_q   <= 1'b0;
`ifndef CSC_LIMITED_RANGE_EN
            s3_tag_q   <= '0;
`endif
            vdata_q    <= '0;
        end else begin
            s1_data_q  <= s1_data_d;
            s1_tag_q   <= s1_tag_d;
            s1_vld_q   <= s1_vld_d;
            s2_carry_q <= s2_carry_d;
            s2_tag_q   <= s2_tag_d;
            s2_vld_q   <= s2_vld_d;
            s3_carry_q <= s3_carry_d;
            s3_vld_q   <= s3_vld_d;
`ifndef CSC_LIMITED_RANGE_EN
            s3_tag_q   <= s3_tag_d;
`endif
            vdata_q    <= vdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: nine products, with coefficients picked by the pixel's tag
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_prod
            localparam int J = gi % 3;      // 0 = R, 1 = G, 2 = B
            logic signed [CW-1:0]    kc;
            logic signed [ACC_W-1:0] px_ext, kc_ext;
            logic signed [ACC_W-1:0] prod_d, prod_q;

            // Coefficient select and multiply.
            always_comb begin
                case (s1_tag_q)
                    M_601:   kc = K601[gi];
                    M_709:   kc = K709[gi];
                    default: kc = KBYP[gi];
                endcase
                px_ext = ACC_W'($signed({1'b0, s1_data_q[(2-J)*COLOR_W +: COLOR_W]}));
                kc_ext = ACC_W'(kc);
                prod_d = px_ext * kc_ext;
            end

            // Product register.
            always_ff @(posedge VCLK) begin
                if (VRST) begin
                    prod_q <= '0;
                end else begin
                    prod_q <= prod_d;
                end
            end
        end

        // --------------------------------------------------------------
        // Stage 3: per-channel sum plus offset; stage 4: round and clamp
        // --------------------------------------------------------------
        for (gi = 0; gi < 3; gi++) begin : g_ch
            logic signed [ACC_W-1:0] off;
            logic signed [ACC_W-1:0] acc_d, acc_q;
            logic signed [ACC_W-1:0] sh;
            logic [COLOR_W-1:0]      val;

            // Accumulate the three products of this channel with its offset.
            always_comb begin
                off   = (s2_tag_q == M_BYP) ? OFF_BYP[gi] : OFF_YPB[gi];
                acc_d = g_prod[3*gi].prod_q + g_prod[3*gi+1].prod_q
                      + g_prod[3*gi+2].prod_q + off;
            end

            // Accumulator register.
            always_ff @(posedge VCLK) begin
                if (VRST) begin
                    acc_q <= '0;
                end else begin
                    acc_q <= acc_d;
                end
            end

            // Round half-up, then saturate into the channel range.
            always_comb begin
                sh = (acc_q + HALF) >>> COEFF_W;
                if (sh[ACC_W-1]) begin
                    val = '0;
                end else if (sh > MAXV) begin
                    val = '1;
                end else begin
                    val = sh[COLOR_W-1:0];
                end
            end
        end
    endgenerate

    // Output assembly. Sync bits come from the carry untouched. Full-range bypass
    // takes the delayed raw pixel. Invalid slots read as zero.
    always_comb begin
        conv = {s3_carry_q[CARRY_W-1 -: SYNC_W], g_ch[0].val, g_ch[1].val, g_ch[2].val};
`ifndef CSC_LIMITED_RANGE_EN
        if (s3_tag_q == M_BYP) begin
            conv = s3_carry_q;
        end
`endif
        vdata_d = s3_vld_q ? conv : '0;
    end

    assign vdata_o = vdata_q;

endmodule

// File: tb/tb_n64a_csc_pipe.sv
// Self-checking bench for n64a_csc_pipe (default full-range build, 8-bit channels).
// Directed pixels push their expected output into a scoreboard with a due cycle.
// A monitor on the falling edge pops each entry and compares it.
module tb_n64a_csc_pipe;

    localparam int PW = 28;

    logic          VCLK = 1'b0;
    logic          VRST;
    logic [1:0]    mode_i;
    logic [PW-1:0] vdata_i;
    logic [PW-1:0] vdata_o;
    logic [1:0]    mode_o;
    logic          pend_o;

    n64a_csc_pipe #(.COLOR_W(8), .COEFF_W(18), .SYNC_W(4)) dut (
        .VCLK    (VCLK),
        .VRST    (VRST),
        .mode_i  (mode_i),
        .vdata_i (vdata_i),
        .vdata_o (vdata_o),
        .mode_o  (mode_o),
        .pend_o  (pend_o)
    );

    always #5 VCLK = ~VCLK;

    int cyc = 0;
    always @(posedge VCLK) cyc <= cyc + 1;

    typedef struct {
        int            due;
        logic [PW-1:0] exp;
        string         nm;
    } sb_t;

    sb_t sb[$];
    int  checks   = 0;
    int  failures = 0;

    function automatic logic [PW-1:0] px(input logic [3:0] s, input logic [7:0] a,
                                         input logic [7:0] b, input logic [7:0] c);
        return {s, a, b, c};
    endfunction

    task automatic step(input logic rst, input logic [1:0] m, input logic [PW-1:0] d,
                        input bit chk_en, input logic [PW-1:0] exp, input string nm);
        VRST    = rst;
        mode_i  = m;
        vdata_i = d;
        if (chk_en) sb.push_back('{cyc + 4, exp, nm});
        @(posedge VCLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end else begin
            $display("chk  %s got=%0h ok", nm, act);
        end
    endtask

    // Scoreboard monitor
    always @(negedge VCLK) begin
        sb_t e;
        if (sb.size() > 0 && sb[0].due < cyc) begin
            e = sb.pop_front();
            checks++;
            failures++;
            $display("FAIL %s missed due=%0d now=%0d", e.nm, e.due, cyc);
        end else if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            checks++;
            if (vdata_o !== e.exp) begin
                failures++;
                $display("FAIL %s cyc=%0d got=%h exp=%h", e.nm, cyc, vdata_o, e.exp);
            end else begin
                $display("pix  %s cyc=%0d got=%h ok", e.nm, cyc, vdata_o);
            end
        end
    end

    localparam logic [3:0] SH = 4'b1010;   // nVSYNC high
    localparam logic [3:0] SL = 4'b0010;   // nVSYNC low

    initial begin
        logic [PW-1:0] d;
        logic [1:0]    m;
        int            n;

        VRST = 1'b1; mode_i = 2'b01; vdata_i = '0;
        repeat (3) begin @(posedge VCLK); #1; end
        chk("rst_vdata", vdata_o, 0);
        chk("rst_mode", mode_o, 1);
        chk("rst_pend", pend_o, 0);

        // 601 conversions
        step(0, 2'b01, px(SH, 255, 255, 255), 1, px(SH, 128, 255, 128), "white601");
        chk("run_mode", mode_o, 1);
        chk("run_pend", pend_o, 0);
        step(0, 2'b01, px(SH, 255, 0, 0),   1, px(SH, 255, 76, 85), "red601_clamp");
        step(0, 2'b01, px(SH, 255, 255, 0), 1, px(SH, 149, 226, 1), "yellow601");

        // Mid-frame switch 601 -> 709, applied on the nVSYNC falling pixel
        step(0, 2'b10, px(SH, 255, 0, 0), 1, px(SH, 255, 76, 85), "red_before_sw");
        chk("sw_pend", pend_o, 1);
        chk("sw_mode_hold", mode_o, 1);
        step(0, 2'b10, px(SL, 0, 0, 255), 1, px(SL, 116, 18, 255), "blue709_edge");
        chk("sw_mode_new", mode_o, 2);
        chk("sw_pend_clr", pend_o, 0);

        // Cancel: the request returns to the current mode before the boundary
        step(0, 2'b01, px(SH, 0, 0, 255), 1, px(SH, 116, 18, 255), "blue709_a");
        chk("cancel_pend_set", pend_o, 1);
        chk("cancel_mode_hold", mode_o, 2);
        step(0, 2'b10, px(SH, 0, 0, 255), 1, px(SH, 116, 18, 255), "blue709_b");
        chk("cancel_pend_clr", pend_o, 0);
        step(0, 2'b10, px(SL, 0, 0, 255), 1, px(SL, 116, 18, 255), "blue709_frame");
        chk("cancel_mode_kept", mode_o, 2);

        // Switch to bypass, then mode 11 acts as 00
        step(0, 2'b00, px(SH, 0, 0, 255), 1, px(SH, 116, 18, 255), "blue709_c");
        chk("byp_pend", pend_o, 1);
        step(0, 2'b00, px(SL, 12, 34, 56), 1, px(SL, 12, 34, 56), "byp_first");
        chk("byp_mode", mode_o, 0);
        chk("byp_pend_clr", pend_o, 0);
        step(0, 2'b11, px(4'b1011, 200, 100, 50), 1, px(4'b1011, 200, 100, 50), "byp_m11");
        chk("m11_pend", pend_o, 0);
        chk("m11_mode", mode_o, 0);
        for (int i = 0; i < 12; i++) begin
            d = PW'($urandom);
            m = (i % 2 == 1) ? 2'b11 : 2'b00;
            step(0, m, d, 1, d, "byp_rand");
        end

        // Reset mid-stream while a request is pending
        step(0, 2'b10, px(SH, 1, 2, 3), 0, '0, "");
        chk("pre_rst_pend", pend_o, 1);
        step(0, 2'b10, px(SH, 4, 5, 6), 0, '0, "");
        step(0, 2'b10, px(SH, 7, 8, 9), 0, '0, "");
        for (int k = 1; k <= 4; k++) sb.push_back('{cyc + k, '0, "rst_flush"});
        step(1, 2'b01, px(SH, 10, 11, 12), 0, '0, "");
        chk("post_rst_pend", pend_o, 0);
        chk("post_rst_mode", mode_o, 1);
        step(0, 2'b01, px(SH, 255, 255, 255), 1, px(SH, 128, 255, 128), "white601_post");

        // Drain with a bounded wait
        n = 0;
        while (sb.size() > 0 && n < 20) begin
            step(0, 2'b01, '0, 0, '0, "");
            n++;
        end
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout pending=%0d exp=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
